// File: rtl/ksa_pkg.sv
// ksa_pkg: shared state encoding and default widths for the RC4 key-scheduling core
package ksa_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int KEY_LEN_DEF = 3;
  typedef enum logic [3:0] {
    IDLE, FILL, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, DONE
  } state_t;
endpackage

// File: rtl/ksa_if.sv
// ksa_if: control handshake plus external S-memory port of the key-scheduling core
interface ksa_if import ksa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF
) ();
  logic start;
  logic init_only;
  logic [KEY_LEN*DATA_W-1:0] key;
  logic busy;
  logic finish;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wr_data;
  logic mem_wr_en;
  logic [DATA_W-1:0] mem_rd_data;
  modport master (
    output start, init_only, key, mem_rd_data,
    input busy, finish, mem_addr, mem_wr_data, mem_wr_en
  );
  modport slave (
    input start, init_only, key, mem_rd_data,
    output busy, finish, mem_addr, mem_wr_data, mem_wr_en
  );
endinterface

// File: rtl/ksa_core.sv
// ksa_core: RC4 key-scheduling FSM driving an external S-memory with one-cycle read latency
module ksa_core import ksa_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int KEY_LEN = KEY_LEN_DEF
) (
  input logic clk,
  input logic reset,
  ksa_if.slave bus
);
  localparam int KW = KEY_LEN > 1 ? $clog2(KEY_LEN) : 1;
  localparam logic [DATA_W-1:0] LAST = '1;
  state_t state, state_n;
  logic [DATA_W-1:0] i, j, si, sj, kel;
  logic [KW-1:0] kidx;
  logic [KEY_LEN*DATA_W-1:0] key_q;
  logic io_q;
  logic wr;
  logic [DATA_W-1:0] ke [KEY_LEN];
  // split the latched key into elements, element 0 from the most significant bits
  always_comb
    for (int k = 0; k < KEY_LEN; k++) ke[k] = key_q[DATA_W*(KEY_LEN-1-k) +: DATA_W];
  assign kel = ke[kidx];
  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? FILL : IDLE;
      FILL: state_n = (i == LAST) ? (io_q ? DONE : RD_I) : FILL;
      RD_I: state_n = WAIT_I;
      WAIT_I: state_n = CALC_J;
      CALC_J: state_n = RD_J;
      RD_J: state_n = WAIT_J;
      WAIT_J: state_n = WR_I;
      WR_I: state_n = WR_J;
      WR_J: state_n = (i == LAST) ? DONE : RD_I;
      default: state_n = IDLE;
    endcase
  end
  assign wr = state == FILL || state == WR_I || state == WR_J;
  assign bus.busy = !reset && state != IDLE;
  assign bus.finish = !reset && state == DONE;
  assign bus.mem_wr_en = !reset && wr;
  assign bus.mem_addr = (reset || state == IDLE || state == DONE) ? '0 :
                        (state == RD_J || state == WAIT_J || state == WR_J) ? j : i;
  assign bus.mem_wr_data = reset ? '0 : state == FILL ? i : state == WR_I ? sj :
                           state == WR_J ? si : '0;
  // state register and datapath; i wraps to 0 naturally after the last fill/swap
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i <= '0;
      j <= '0;
      kidx <= '0;
      si <= '0;
      sj <= '0;
      key_q <= '0;
      io_q <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (bus.start) begin
          key_q <= bus.key;
          io_q <= bus.init_only;
          i <= '0;
          j <= '0;
          kidx <= '0;
        end
        FILL: i <= i + DATA_W'(1);
        WAIT_I: si <= bus.mem_rd_data;
        CALC_J: j <= j + si + kel;
        WAIT_J: sj <= bus.mem_rd_data;
        WR_J: begin
          i <= i + DATA_W'(1);
          kidx <= (kidx == KW'(KEY_LEN-1)) ? '0 : kidx + KW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ksa_core.sv
// tb_ksa_core: directed checks of the key-scheduling core at 8-bit/3-key and 2-bit/1-key sizes
module tb_ksa_core;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b1;
  int total = 0;
  int bad = 0;
  int wr8;
  int c1, c2;
  logic [7:0] m8 [256];
  logic [7:0] rs [256];
  logic [1:0] m2 [4];
  logic [1:0] exp2 [4] = '{2'd0, 2'd2, 2'd3, 2'd1};

  ksa_if #(.DATA_W(8), .KEY_LEN(3)) b8 ();
  ksa_if #(.DATA_W(2), .KEY_LEN(1)) b2 ();

  ksa_core #(.DATA_W(8), .KEY_LEN(3)) u8 (.clk(clk), .reset(rst), .bus(b8));
  ksa_core #(.DATA_W(2), .KEY_LEN(1)) u2 (.clk(clk), .reset(rst), .bus(b2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (b8.mem_wr_en) m8[b8.mem_addr] <= b8.mem_wr_data;
    b8.mem_rd_data <= m8[b8.mem_addr];
    if (b2.mem_wr_en) m2[b2.mem_addr] <= b2.mem_wr_data;
    b2.mem_rd_data <= m2[b2.mem_addr];
    wr8 <= clr ? 0 : wr8 + (b8.mem_wr_en ? 1 : 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ref_ksa(input logic [23:0] k);
    logic [7:0] j, t;
    logic [7:0] kb [3];
    kb[0] = k[23:16];
    kb[1] = k[15:8];
    kb[2] = k[7:0];
    j = 8'd0;
    for (int x = 0; x < 256; x++) rs[x] = x[7:0];
    for (int x = 0; x < 256; x++) begin
      j = j + rs[x] + kb[x % 3];
      t = rs[x];
      rs[x] = rs[j];
      rs[j] = t;
    end
  endtask

  task automatic chk_out8(input string tag);
    chk({tag, "_busy"}, 32'(b8.busy), 0);
    chk({tag, "_finish"}, 32'(b8.finish), 0);
    chk({tag, "_we"}, 32'(b8.mem_wr_en), 0);
    chk({tag, "_addr"}, 32'(b8.mem_addr), 0);
    chk({tag, "_wdata"}, 32'(b8.mem_wr_data), 0);
  endtask

  task automatic chk_mem8();
    for (int x = 0; x < 256; x++) chk("mem8", 32'(m8[x]), 32'(rs[x]));
  endtask

  task automatic run8(input logic io, input logic [23:0] k, input int pulse_at,
                      input int rst_at, output int cyc);
    int n;
    logic bz;
    @(negedge clk);
    b8.key = k;
    b8.init_only = io;
    b8.start = 1'b1;
    clr = 1'b1;
    @(negedge clk);
    b8.start = 1'b0;
    clr = 1'b0;
    n = 1;
    bz = 1'b1;
    cyc = -1;
    while (n < 5000) begin
      if (b8.finish) begin
        cyc = n;
        break;
      end
      if (!b8.busy) bz = 1'b0;
      b8.start = (n == pulse_at);
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk_out8("abort");
        rst = 1'b0;
        break;
      end
      @(negedge clk);
      n++;
    end
    b8.start = 1'b0;
    if (rst_at == 0) chk("busy_held", 32'(bz), 1);
  endtask

  task automatic run2(input logic hold, output int f1, output int f2);
    int n;
    @(negedge clk);
    b2.key = 2'd0;
    b2.init_only = 1'b0;
    b2.start = 1'b1;
    @(negedge clk);
    if (!hold) b2.start = 1'b0;
    n = 1;
    f1 = -1;
    f2 = -1;
    while (n < 200) begin
      if (n == 19 && !hold)
        for (int x = 0; x < 4; x++) chk("same_swap", 32'(m2[x]), x);
      if (b2.finish) begin
        if (f1 < 0) begin
          f1 = n;
          if (!hold) break;
        end else begin
          f2 = n;
          break;
        end
      end
      @(negedge clk);
      n++;
    end
    b2.start = 1'b0;
  endtask

  initial begin
    b8.start = 1'b0;
    b8.init_only = 1'b0;
    b8.key = '0;
    b2.start = 1'b0;
    b2.init_only = 1'b0;
    b2.key = '0;
    rst = 1'b1;
    b8.start = 1'b1;
    repeat (3) @(negedge clk);
    chk_out8("in_reset");
    chk("in_reset_busy2", 32'(b2.busy), 0);
    b8.start = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_out8("idle");

    ref_ksa(24'h000249);
    run8(1'b0, 24'h000249, 0, 0, c1);
    chk("full_latency", c1, 2049);
    chk_mem8();
    chk("hand_s0", 32'(rs[0]) == 32'(m8[0]) ? 32'(m8[0]) : 32'hdead, 32'(rs[0]));

    run8(1'b0, 24'h000249, 100, 0, c1);
    chk("restart_ignored_latency", c1, 2049);
    chk_mem8();

    run8(1'b0, 24'h0a1b2c, 0, 700, c1);
    chk("aborted_no_finish", c1, 32'hffffffff);
    ref_ksa(24'h0a1b2c);
    run8(1'b0, 24'h0a1b2c, 0, 0, c1);
    chk("post_abort_latency", c1, 2049);
    chk_mem8();

    run8(1'b1, 24'h000249, 0, 0, c1);
    chk("init_latency", c1, 257);
    chk("init_writes", wr8, 256);
    for (int x = 0; x < 256; x++) chk("init_mem", 32'(m8[x]), x);

    run2(1'b0, c1, c2);
    chk("small_latency", c1, 33);
    for (int x = 0; x < 4; x++) chk("small_mem", 32'(m2[x]), 32'(exp2[x]));

    run2(1'b1, c1, c2);
    chk("held_first", c1, 33);
    chk("held_second", c2, 67);
    for (int x = 0; x < 4; x++) chk("held_mem", 32'(m2[x]), 32'(exp2[x]));

    repeat (3) @(negedge clk);
    chk("idle_after_hold", 32'(b2.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
